// File: rtl/filter2d_pkg.sv
// Constants shared by filter2d and its stream-out stage: frame geometry, SRAM layout
// and the common FSM encoding.
package filter2d_pkg;

  localparam int WIDTH    = 256;
  localparam int ADDR_W   = 17;
  localparam int OUT_BASE = WIDTH * WIDTH;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // One prefetched pixel with its frame markers, as held in the output FIFO.
  typedef struct packed {
    logic       sof;
    logic       eol;
    logic [7:0] data;
  } px_t;

endpackage

// File: rtl/px_fifo.sv
// Small register-based synchronous FIFO for prefetched pixels. DEPTH must be a power
// of two so the pointers wrap naturally.
module px_fifo #(
  parameter int DATA_W = 10,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        din,
  output logic [DATA_W-1:0]        dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/filter2d_stream_out.sv
// Reads the filtered frame back from the output region of the shared SRAM and streams
// it out as an 8-bit valid/ready pixel stream with start-of-frame and end-of-line flags.
module filter2d_stream_out
  import filter2d_pkg::*;
#(
  parameter int WIDTH      = filter2d_pkg::WIDTH,
  parameter int ADDR_W     = filter2d_pkg::ADDR_W,
  parameter int BASE       = WIDTH * WIDTH,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              cs,
  output logic              we,
  output logic [ADDR_W-1:0] addr,
  input  logic [7:0]        dout,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [7:0]        m_data,
  output logic              m_sof,
  output logic              m_eol,
  output logic [1:0]        dbg_state
);

  localparam int XW = $clog2(WIDTH);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [XW-1:0]     X_LAST  = XW'(WIDTH - 1);
  localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(BASE);
  localparam logic [ADDR_W-1:0] WIDTH_A = ADDR_W'(WIDTH);

  logic [1:0]    state;
  logic [XW-1:0] rd_x;
  logic [XW-1:0] rd_y;
  logic          pend;
  logic          sof_d;
  logic          eol_d;
  logic          run;
  logic          last_rd;
  logic          push;
  logic          pop;
  logic          last_pop;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic          fifo_full;
  px_t           din;
  px_t           head;

  // Stream handshake: a pixel transfers on a rising clk edge where m_valid & m_ready;
  // while m_valid & ~m_ready the head word is held unchanged.
  assign run     = (state == ST_RUN);
  assign last_rd = (rd_x == X_LAST) && (rd_y == X_LAST);

  // Credit: buffered plus in-flight reads never exceed the FIFO depth, so a capture
  // always finds room.
  assign cs   = run && ((fifo_count + CW'(pend)) < CW'(FIFO_DEPTH));
  assign we   = 1'b0;
  assign addr = run ? (BASE_A + WIDTH_A * ADDR_W'(rd_y) + ADDR_W'(rd_x)) : '0;

  assign din  = '{sof: sof_d, eol: eol_d, data: dout};
  assign push = pend & ~fifo_full;
  assign pop  = m_valid & m_ready;

  // With every read issued and nothing in flight, the last buffered word is the frame's
  // final pixel.
  assign last_pop = (state == ST_DRAIN) && pop && head.eol && !pend &&
                    (fifo_count == CW'(1));

  assign m_valid   = ~fifo_empty;
  assign m_data    = head.data;
  assign m_sof     = head.sof;
  assign m_eol     = head.eol;
  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      rd_x  <= '0;
      rd_y  <= '0;
      pend  <= 1'b0;
      sof_d <= 1'b0;
      eol_d <= 1'b0;
      done  <= 1'b0;
    end else begin
      pend <= cs;
      done <= last_pop;
      if (cs) begin
        sof_d <= (rd_x == '0) && (rd_y == '0);
        eol_d <= (rd_x == X_LAST);
      end
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_RUN;
            rd_x  <= '0;
            rd_y  <= '0;
          end
        end
        ST_RUN: begin
          if (cs) begin
            if (rd_x == X_LAST) begin
              rd_x <= '0;
              rd_y <= rd_y + 1'b1;
            end else begin
              rd_x <= rd_x + 1'b1;
            end
            if (last_rd) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (last_pop) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  px_fifo #(
    .DATA_W(10),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .push   (push),
    .pop    (pop),
    .din    (din),
    .dout   (head),
    .count  (fifo_count),
    .empty  (fifo_empty),
    .full   (fifo_full)
  );

endmodule
